// File: rtl/fns_decoder_5_4_pkg.sv
// rtl/fns_decoder_5_4_pkg.sv - shared constants and helpers for the FNS 5-to-4 decoder
package fns_decoder_5_4_pkg;

  // Codeword geometry: 9 TSVs, split into a 5-bit lo slice and a 4-bit hi slice.
  localparam int NUM_TSV = 9;
  localparam int LO_BITS = 5;
  localparam int HI_BITS = NUM_TSV - LO_BITS;

  // Data and weight widths (BLEN_05 / FNSLEN_06 of the shared Fibonacci header).
  localparam int BLEN_05   = 7;
  localparam int FNSLEN_06 = 6;

  // Reference FNS weight set for code bits 1..8 (bit 0 weight is 1).
  localparam int FNS_REF_02 = 2;
  localparam int FNS_REF_03 = 3;
  localparam int FNS_REF_04 = 5;
  localparam int FNS_REF_05 = 8;
  localparam int FNS_REF_06 = 13;
  localparam int FNS_REF_07 = 21;
  localparam int FNS_REF_08 = 34;
  localparam int FNS_REF_09 = 55;

  // Two adjacent set bits can never come out of the greedy encoder.
  function automatic logic has_adjacent_ones(input logic [NUM_TSV-1:0] m);
    return |(m[NUM_TSV-1:1] & m[NUM_TSV-2:0]);
  endfunction

endpackage

// File: rtl/fns_decoder_5_4_wsum_lane.sv
// rtl/fns_decoder_5_4_wsum_lane.sv - masked weighted adder over an N-bit codeword slice
module fns_wsum_lane
  import fns_decoder_5_4_pkg::*;
#(
  parameter int N  = LO_BITS,
  parameter int WW = FNSLEN_06,
  parameter int OW = BLEN_05 + 1
) (
  input  logic [N-1:0]    bits,
  input  logic [N*WW-1:0] weights,
  output logic [OW-1:0]   sum
);

  // Accumulate the weight of every set (already masked) bit.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      if (bits[i]) begin
        sum = sum + OW'(weights[i*WW +: WW]);
      end
    end
  end

endmodule

// File: rtl/fns_decoder_5_4.sv
// rtl/fns_decoder_5_4.sv - two-stage FNS codeword decoder; optional range check via DEC_RANGE_CHK_EN
module fns_decoder_5_4
  import fns_decoder_5_4_pkg::*;
#(
  parameter int DW = BLEN_05,
  parameter int WW = FNSLEN_06
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_TSV-1:0]   code_in,
  input  logic [NUM_TSV-1:0]   en_flag,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WW-1:0]        FNS02,
  input  logic [WW-1:0]        FNS03,
  input  logic [WW-1:0]        FNS04,
  input  logic [WW-1:0]        FNS05,
  input  logic [WW-1:0]        FNS06,
  input  logic [WW-1:0]        FNS07,
  input  logic [WW-1:0]        FNS08,
  input  logic [WW-1:0]        FNS09,
  output logic [DW-1:0]        data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_err
);

  logic [NUM_TSV-1:0] m;
  logic [DW:0]        hi_sum;
  logic [DW:0]        lo_sum;
  logic [DW:0]        hi_q;
  logic [DW:0]        lo_q;
  logic [DW:0]        full_sum;
  logic               s1_valid;
  logic               adv2;
  logic               adv1;

  assign m        = code_in & en_flag;
  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign full_sum = hi_q + lo_q;

  fns_wsum_lane #(.N(HI_BITS), .WW(WW), .OW(DW + 1)) u_hi (
    .bits    (m[NUM_TSV-1:LO_BITS]),
    .weights ({FNS09, FNS08, FNS07, FNS06}),
    .sum     (hi_sum)
  );

  fns_wsum_lane #(.N(LO_BITS), .WW(WW), .OW(DW + 1)) u_lo (
    .bits    (m[LO_BITS-1:0]),
    .weights ({FNS05, FNS04, FNS03, FNS02, WW'(1)}),
    .sum     (lo_sum)
  );

  // Stage 1: capture the masked partial sums when the stage is free to advance.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        hi_q <= hi_sum;
        lo_q <= lo_sum;
      end
    end
  end

  // Stage 2: combine partial sums into the output word; holds while stalled.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out <= full_sum[DW-1:0];
      end
    end
  end

`ifdef DEC_RANGE_CHK_EN
  logic s1_adj;

  // Stage 1 side of the range check: flag encoder-illegal adjacent ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_adj <= 1'b0;
    end else if (adv1 && in_valid) begin
      s1_adj <= has_adjacent_ones(m);
    end
  end

  // Stage 2 side: error travels with its word, overflow when the sum reaches 2^DW.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_err <= 1'b0;
    end else if (adv2 && s1_valid) begin
      out_err <= full_sum[DW] || s1_adj;
    end
  end
`else
  logic unused_sum_msb;
  assign unused_sum_msb = full_sum[DW];
  assign out_err        = 1'b0;
`endif

endmodule

// File: tb/tb_fns_decoder_5_4.sv
// tb/tb_fns_decoder_5_4.sv - self-checking bench for fns_decoder_5_4
module tb_fns_decoder_5_4;

  localparam int DW = 7;
  localparam int WW = 6;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [8:0]    code_in = '0;
  logic [8:0]    en_flag = 9'h1FF;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [WW-1:0] FNS02 = 6'd2;
  logic [WW-1:0] FNS03 = 6'd3;
  logic [WW-1:0] FNS04 = 6'd5;
  logic [WW-1:0] FNS05 = 6'd8;
  logic [WW-1:0] FNS06 = 6'd13;
  logic [WW-1:0] FNS07 = 6'd21;
  logic [WW-1:0] FNS08 = 6'd34;
  logic [WW-1:0] FNS09 = 6'd55;
  logic [DW-1:0] data_out;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_err;

  int tests = 0;
  int fails = 0;
  int weight_tab [9] = '{1, 2, 3, 5, 8, 13, 21, 34, 55};
  int exp_q [$];
  int got;

  fns_decoder_5_4 #(.DW(DW), .WW(WW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .code_in   (code_in),
    .en_flag   (en_flag),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .FNS02     (FNS02),
    .FNS03     (FNS03),
    .FNS04     (FNS04),
    .FNS05     (FNS05),
    .FNS06     (FNS06),
    .FNS07     (FNS07),
    .FNS08     (FNS08),
    .FNS09     (FNS09),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_err   (out_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference: full weighted sum of the enabled, set code bits.
  function automatic int ref_sum(input logic [8:0] c, input logic [8:0] e);
    int s = 0;
    for (int i = 0; i < 9; i++) if (c[i] && e[i]) s += weight_tab[i];
    return s;
  endfunction

  function automatic int ref_err(input logic [8:0] c, input logic [8:0] e);
    int bad = 0;
`ifdef DEC_RANGE_CHK_EN
    if (ref_sum(c, e) >= (1 << DW)) bad = 1;
    for (int i = 1; i < 9; i++) if (c[i] && c[i-1] && e[i] && e[i-1]) bad = 1;
`endif
    return bad;
  endfunction

  // Single word with an idle pipe: output must appear exactly two edges later.
  task automatic run_one(input string tag, input logic [8:0] c, input logic [8:0] e,
                         input int exp_data, input int exp_err);
    code_in = c; en_flag = e; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check({tag, "_early"}, out_valid, 0);
    tick();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_err"}, out_err, exp_err);
    tick();
  endtask

  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", data_out, 0);
    check("rst_err", out_err, 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    run_one("b8b0", 9'b100000001, 9'h1FF, 56, 0);
    run_one("alt", 9'b010101010, 9'h1FF, 54, 0);
    run_one("mask8", 9'b100000001, 9'b011111111, 1, 0);

    // Back-to-back stream, one word per cycle.
    en_flag = 9'h1FF;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k < 4);
      code_in  = (k == 0) ? 9'd0 : 9'(1 << (k - 1));
      #1;
      if (k < 4) check($sformatf("b2b_ready%0d", k), in_ready, 1);
      tick();
      if (k >= 1 && k <= 4) begin
        check($sformatf("b2b_valid%0d", k), out_valid, 1);
        check($sformatf("b2b_data%0d", k), data_out, k - 1);
      end
    end
    in_valid = 1'b0;
    tick();

    // Stall: three pushes against a blocked sink.
    out_ready = 1'b0;
    in_valid = 1'b1; code_in = 9'h003; #1;
    check("stall_rdy_a", in_ready, 1);
    tick();
    code_in = 9'h010; #1;
    check("stall_rdy_b", in_ready, 1);
    tick();
    code_in = 9'h100;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("stall_rdy_low%0d", k), in_ready, 0);
      check($sformatf("stall_hold%0d", k), data_out, 3);
      check($sformatf("stall_valid%0d", k), out_valid, 1);
      tick();
    end
    out_ready = 1'b1; #1;
    check("rel_a", data_out, 3);
    check("rel_rdy", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("rel_b", data_out, 8);
    tick();
    check("rel_c", data_out, 55);
    check("rel_c_valid", out_valid, 1);
    tick();
    check("rel_empty", out_valid, 0);

    // Asynchronous reset with two words in flight.
    in_valid = 1'b1; code_in = 9'h005;
    tick();
    code_in = 9'h00A;
    tick();
    in_valid = 1'b0;
    check("mid_pre_valid", out_valid, 1);
    reset_n = 1'b0; #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", data_out, 0);
    tick();
    reset_n = 1'b1;
    tick();
    check("mid_empty", out_valid, 0);
    run_one("post_rst", 9'b010101010, 9'h1FF, 54, 0);

`ifdef DEC_RANGE_CHK_EN
    run_one("err_adj", 9'b110000000, 9'h1FF, 89, 1);
    run_one("err_ok", 9'b101000000, 9'h1FF, 76, 0);
`endif

    // Randomized traffic against the queue model.
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      code_in   = 9'($urandom);
      en_flag   = ($urandom_range(0, 1) != 0) ? 9'h1FF : 9'($urandom);
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("rnd_spurious", 1, 0);
        end else begin
          got = exp_q.pop_front();
          check("rnd_data", data_out, got % (1 << DW));
          check("rnd_err", out_err, got >> 16);
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_sum(code_in, en_flag) + (ref_err(code_in, en_flag) << 16));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 10 && exp_q.size() > 0; n++) begin
      #1;
      if (out_valid) begin
        got = exp_q.pop_front();
        check("drain_data", data_out, got % (1 << DW));
        check("drain_err", out_err, got >> 16);
      end
      tick();
    end
    check("drain_left", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
